// File: rtl/seq_alu.sv
// Sequential 32-bit ALU: single-cycle ADD/COMP/AND/XOR and bit-serial shifts.
// Define SEQ_ALU_BARREL_EN to replace the iterative shifter with a one-cycle barrel shifter.
module seq_alu (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry,
  output logic        zero,
  output logic        sign
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_COMP = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SHLL = 4'd4;
  localparam logic [3:0] OP_SHRL = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;

  // Returns {carry, result}; the extra bit of the shift operand catches the last bit out.
  function automatic logic [32:0] single_op(input logic [3:0] f_op, input logic [31:0] f_a,
                                            input logic [31:0] f_b, input logic [4:0] f_amt);
    logic [32:0] r;
    logic [32:0] ext;
    ext = 33'd0;
    case (f_op)
      OP_ADD:  r = {1'b0, f_a} + {1'b0, f_b};
      OP_COMP: r = {1'b0, ~f_b + 32'd1};
      OP_AND:  r = {1'b0, f_a & f_b};
      OP_XOR:  r = {1'b0, f_a ^ f_b};
      OP_SHLL: r = {1'b0, f_a} << f_amt;
      OP_SHRL: begin
        ext = {f_a, 1'b0} >> f_amt;
        r   = {ext[0], ext[32:1]};
      end
      OP_SHRA: begin
        ext = $signed({f_a, 1'b0}) >>> f_amt;
        r   = {ext[0], ext[32:1]};
      end
      default: r = 33'd0;
    endcase
    return r;
  endfunction

  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic        load_en;
  logic [32:0] load_val;

`ifdef SEQ_ALU_BARREL_EN

  assign busy = 1'b0;

  // Every operation, shifts included, completes on the accepting edge.
  always_comb begin
    load_en  = 1'b0;
    load_val = 33'd0;
    if (start) begin
      load_en  = 1'b1;
      load_val = single_op(op, a, b, b[4:0]);
    end else begin
      load_en  = 1'b0;
    end
  end

`else

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  sop_q, sop_d;
  logic [32:0] step;
  logic        is_shift;

  // One-bit shift step, returning {bit shifted out, shifted word}.
  function automatic logic [32:0] shift_step(input logic [3:0] f_op, input logic [31:0] f_w);
    logic [32:0] r;
    case (f_op)
      OP_SHLL: r = {f_w[31], f_w[30:0], 1'b0};
      OP_SHRL: r = {f_w[0], 1'b0, f_w[31:1]};
      OP_SHRA: r = {f_w[0], f_w[31], f_w[31:1]};
      default: r = 33'd0;
    endcase
    return r;
  endfunction

  assign busy     = (state_q == SHIFT);
  assign is_shift = (op == OP_SHLL) || (op == OP_SHRL) || (op == OP_SHRA);

  // Next-state logic; the partial shift lives in work_q so result only changes on completion.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    load_en  = 1'b0;
    load_val = 33'd0;
    step     = shift_step(sop_q, work_q);
    case (state_q)
      IDLE: begin
        if (start && is_shift && (b[4:0] != 5'd0)) begin
          state_d = SHIFT;
          work_d  = a;
          cnt_d   = b[4:0];
          sop_d   = op;
        end else if (start) begin
          load_en  = 1'b1;
          load_val = single_op(op, a, b, 5'd0);
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = step[31:0];
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d  = IDLE;
          load_en  = 1'b1;
          load_val = step;
          work_d   = 32'd0;
          cnt_d    = 5'd0;
          sop_d    = 4'd0;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shifter state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      cnt_q   <= 5'd0;
      sop_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
    end
  end

`endif

  // Result and flags hold until the next completed operation.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    if (load_en) begin
      result_d = load_val[31:0];
      carry_d  = load_val[32];
      zero_d   = (load_val[31:0] == 32'd0);
      sign_d   = load_val[31];
      done_d   = 1'b1;
    end else begin
      done_d   = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= 32'd0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign sign   = sign_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu; expected values are hand-computed constants.
module tb_seq_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        sign;

  int total = 0;
  int bad   = 0;
  int lat;

  seq_alu dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .carry (carry),
    .zero  (zero),
    .sign  (sign)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] f_op, input logic [31:0] f_b);
`ifdef SEQ_ALU_BARREL_EN
    return 1;
`else
    if ((f_op >= 4'd4) && (f_op <= 4'd6) && (f_b[4:0] != 5'd0)) return int'(f_b[4:0]) + 1;
    else return 1;
`endif
  endfunction

  // Issue one op at a negedge and wait (bounded) for done; returns in the done cycle.
  task automatic run_op(input string tag, input logic [3:0] f_op, input logic [31:0] f_a,
                        input logic [31:0] f_b);
    start = 1'b1; op = f_op; a = f_a; b = f_b;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat(f_op, f_b));
  endtask

  task automatic expect_out(input string tag, input logic [31:0] r, input logic c,
                            input logic z, input logic s);
    check({tag, "_done"},   done,   32'd1);
    check({tag, "_busy"},   busy,   32'd0);
    check({tag, "_result"}, result, r);
    check({tag, "_carry"},  carry,  c);
    check({tag, "_zero"},   zero,   z);
    check({tag, "_sign"},   sign,   s);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_carry", carry, 32'd0);
    check("rst_zero", zero, 32'd0);
    check("rst_sign", sign, 32'd0);
    @(negedge clock);

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    expect_out("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    check("add_done_pulse", done, 32'd0);
    check("add_hold", result, 32'h0);

    // SHRA by 4: result must not move while busy
    start = 1'b1; op = 4'd6; a = 32'h8000_0000; b = 32'd4;
    @(negedge clock);
    start = 1'b0;
`ifndef SEQ_ALU_BARREL_EN
    for (int i = 0; i < 4; i++) begin
      check("shra_busy", busy, 32'd1);
      check("shra_nodone", done, 32'd0);
      check("shra_hidden", result, 32'h0);
      @(negedge clock);
    end
`endif
    expect_out("shra", 32'hF800_0000, 1'b0, 1'b0, 1'b1);
    @(negedge clock);

    run_op("shll1", 4'd4, 32'h8000_0001, 32'd1);
    expect_out("shll1", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    run_op("shll0", 4'd4, 32'h8000_0001, 32'd0);
    expect_out("shll0", 32'h8000_0001, 1'b0, 1'b0, 1'b1);
    run_op("shrl5", 4'd5, 32'h0000_00F0, 32'd5);
    expect_out("shrl5", 32'h0000_0007, 1'b1, 1'b0, 1'b0);
    run_op("shra5", 4'd6, 32'h8000_0010, 32'd5);
    expect_out("shra5", 32'hFC00_0000, 1'b1, 1'b0, 1'b1);
    run_op("shll31", 4'd4, 32'h0000_0003, 32'hFFFF_FFFF);
    expect_out("shll31", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    run_op("comp", 4'd1, 32'h1234_5678, 32'd5);
    expect_out("comp", 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1);
    run_op("op9", 4'd9, 32'd5, 32'd7);
    expect_out("op9", 32'h0, 1'b0, 1'b1, 1'b0);
    run_op("xor", 4'd3, 32'hA5A5_0F0F, 32'h5A5A_0FF0);
    expect_out("xor", 32'hFFFF_00FF, 1'b0, 1'b0, 1'b1);
    @(negedge clock);

`ifndef SEQ_ALU_BARREL_EN
    // start held high with changing operands during a 3-step shift
    start = 1'b1; op = 4'd4; a = 32'd1; b = 32'd3;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      op = 4'd3; a = 32'hDEAD_0000 + 32'(i); b = 32'd2;
      check("hold_busy", busy, 32'd1);
      check("hold_hidden", result, 32'hFFFF_00FF);
      @(negedge clock);
    end
    expect_out("hold_shll3", 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    op = 4'd2; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
    @(negedge clock);
    start = 1'b0;
    expect_out("b2b_and", 32'hF000_F000, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    check("b2b_single_done", done, 32'd0);

    // reset abandons a long shift; coincident start is ignored
    start = 1'b1; op = 4'd4; a = 32'd1; b = 32'd8;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1; start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("abort_busy", busy, 32'd0);
    check("abort_done", done, 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_zero", zero, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("abort_no_done", done, 32'd0);
    end
    check("abort_result_hold", result, 32'h0);
`endif

    run_op("final_add", 4'd0, 32'h7FFF_FFFF, 32'd1);
    expect_out("final_add", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 The ports SHALL be, one per line, as follows:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request to accept one operation
- op  input  4  operation code, per REQ-005
- a  input  32  operand A, driven by register file read1
- b  input  32  operand B, driven by register file read2 (or by an immediate muxed upstream); b[4:0] is the shift amount
- busy  output  1  high while a multi-cycle operation is in progress
- done  output  1  one-cycle pulse when result and flags are valid
- result  output  32  registered result, written back as write_data
- carry  output  1  registered carry flag
- zero  output  1  registered flag, high when result is 32'h0
- sign  output  1  registered flag, equal to result[31]

Function
REQ-003 The FSM SHALL have two states, IDLE and SHIFT.
- busy SHALL be 1 exactly when the state is SHIFT.
REQ-004 start SHALL be accepted only on a rising edge where the state is IDLE and reset is 0.
- On acceptance, a, b[4:0] and op SHALL be latched.
- start while in SHIFT SHALL be ignored, with no effect on internal state or outputs.
REQ-005 The op encoding SHALL be:
- 0 ADD: a+b, carry = bit 32 of the sum
- 1 COMP: two's complement of b (~b+1), carry 0
- 2 AND: a&b, carry 0
- 3 XOR: a^b, carry 0
- 4 SHLL: logical shift left
- 5 SHRL: logical shift right
- 6 SHRA: arithmetic shift right, filling with a[31]
- 7-15: result 32'h0, carry 0
REQ-006 Single-cycle ops (ops 0-3, 7-15, and shifts with amount 0) SHALL update result and flags, and pulse done, in the first cycle after the accepting edge; the state SHALL remain IDLE.
REQ-007 A shift with amount k (1..31) SHALL enter SHIFT and shift one bit per subsequent rising edge.
- result, flags and done SHALL be updated on the k-th edge after acceptance, so done is high in the (k+1)-th cycle after acceptance.
- The state SHALL return to IDLE on that same edge.
REQ-008 For shifts, carry SHALL equal the last bit shifted out; a shift amount of 0 SHALL give result = a and carry 0.
REQ-009 zero and sign SHALL be derived from the new result at the same edge the result is loaded.
REQ-010 done SHALL be high for exactly one cycle per accepted operation.
- A start in the done cycle SHALL be accepted, giving back-to-back operations.
REQ-011 result, carry, zero and sign SHALL hold their values between done pulses.
- Intermediate shift values SHALL NOT be visible on result.
REQ-012 Arithmetic SHALL be unsigned 32-bit with wrap-around; no overflow flag is produced.

Reset
REQ-013 When reset is 1 at a rising edge, the block SHALL take: state IDLE, busy 0, done 0, result 32'h0, carry 0, zero 0, sign 0.
- All latched operands and the shift counter SHALL be cleared.
REQ-014 reset SHALL take priority over start.
- Reset in SHIFT SHALL abandon the operation with no done pulse.

Configuration
REQ-015 The macro SEQ_ALU_BARREL_EN SHALL select the shifter implementation.
- Defined: all shifts SHALL complete as single-cycle ops per REQ-006 with the same result and carry, and the SHIFT state SHALL be omitted (busy tied 0).
- Undefined: shifts SHALL be iterative per REQ-007.

Verification
REQ-016 ADD, a=32'hFFFFFFFF, b=1 -> done in the 1st cycle after acceptance; result 0, carry 1, zero 1, sign 0.
REQ-017 SHRA, a=32'h80000000, b=4, iterative -> busy high for 4 cycles, done in the 5th cycle; result 32'hF8000000, carry 0, sign 1.
- With SEQ_ALU_BARREL_EN: done in the 1st cycle, same values.
REQ-018 SHLL, a=32'h80000001, b=1 -> result 32'h00000002, carry 1.
- Then SHLL with b=0 -> done in the 1st cycle, result equals a, carry 0.
REQ-019 start held high with changing a/b during a SHIFT of amount 3 -> only the first operation completes.
- A new start in its done cycle -> accepted; second done follows 1 cycle later for an AND.
REQ-020 reset pulsed on the 2nd cycle of a SHIFT of amount 8 -> the next cycle shows busy 0, done 0, result 0, with no later done.
- start coincident with reset -> ignored.
REQ-021 op=9, a=5, b=7 -> done in the 1st cycle; result 0, zero 1, carry 0, sign 0.
